// File: rtl/video_tpg.sv
// AXI-Stream test-pattern source: full active frames of 24-bit {B,G,R} pixels, tuser marks SOF.
// Runs in the pixel clock domain; frames are never truncated once started.
module video_tpg #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic [1:0]  mode_i,
    input  logic [23:0] solid_rgb_i,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o
);
    localparam int unsigned CW    = (CHK_LOG2 >= 16) ? CHK_LOG2 + 1 : 16;
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [CW-1:0] r_bar_x;
    logic [2:0]    r_bar;
    logic [1:0]    r_mode;
    logic [23:0]   r_solid;
    logic [23:0]   r_tdata;
    logic          r_tuser;
    logic          r_done;
    logic [15:0]   r_cnt;

    logic          w_accept;
    logic          w_eol;
    logic          w_eof;
    logic          w_sof;
    logic [CW-1:0] w_x_n;
    logic [CW-1:0] w_y_n;
    logic [CW-1:0] w_bar_x_n;
    logic [2:0]    w_bar_n;
    logic [1:0]    w_mode_n;
    logic [23:0]   w_solid_n;
    logic [23:0]   w_pix_n;

    assign w_accept = (r_state == ST_RUN) && m_axis_tready;
    assign w_eol    = (r_x == CW'(H_ACTIVE - 1));
    assign w_eof    = w_eol && (r_y == CW'(V_ACTIVE - 1));
    // A frame starts from IDLE, or back-to-back right after the last beat is accepted
    assign w_sof    = enable_i && ((r_state == ST_IDLE) || (w_accept && w_eof));

    always_comb begin
        w_mode_n  = r_mode;
        w_solid_n = r_solid;
        w_x_n     = r_x + CW'(1);
        w_y_n     = r_y;
        w_bar_x_n = r_bar_x + CW'(1);
        w_bar_n   = r_bar;
        if (w_sof) begin
            w_mode_n  = mode_i;
            w_solid_n = solid_rgb_i;
            w_x_n     = '0;
            w_y_n     = '0;
            w_bar_x_n = '0;
            w_bar_n   = '0;
        end else begin
            if (w_eol) begin
                w_x_n = '0;
                w_y_n = w_eof ? '0 : r_y + CW'(1);
            end
            // Bar index tracked incrementally to avoid dividing x by H_ACTIVE/8
            if (r_bar_x == CW'(BAR_W - 1)) begin
                w_bar_x_n = '0;
                w_bar_n   = r_bar + 3'd1;
            end
        end
    end

    always_comb begin
        w_pix_n = w_solid_n;
        case (w_mode_n)
            2'd0:    w_pix_n = {{8{~w_bar_n[0]}}, {8{~w_bar_n[2]}}, {8{~w_bar_n[1]}}};
            2'd1:    w_pix_n = {24{w_x_n[CHK_LOG2] ^ w_y_n[CHK_LOG2]}};
            2'd2:    w_pix_n = {w_x_n[7:0] + w_y_n[7:0], w_y_n[7:0], w_x_n[7:0]};
            default: w_pix_n = w_solid_n;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_bar_x <= '0;
            r_bar   <= '0;
            r_mode  <= '0;
            r_solid <= '0;
            r_tdata <= '0;
            r_tuser <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= w_accept && w_eof;
            if (w_accept && w_eof) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_sof || w_accept) begin
                r_x     <= w_x_n;
                r_y     <= w_y_n;
                r_bar_x <= w_bar_x_n;
                r_bar   <= w_bar_n;
                r_mode  <= w_mode_n;
                r_solid <= w_solid_n;
                r_tdata <= w_pix_n;
                r_tuser <= w_sof;
            end
            if (w_sof) begin
                r_state <= ST_RUN;
            end else if (w_accept && w_eof) begin
                r_state <= ST_IDLE;
                r_tdata <= '0;
            end
        end
    end

    assign m_axis_tvalid = (r_state == ST_RUN);
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign frame_done_o  = r_done;
    assign frame_cnt_o   = r_cnt;

endmodule

// File: tb/tb_video_tpg.sv
// Scoreboard bench for video_tpg: expected beats queued as frames are requested, popped on accept.
module tb_video_tpg;
    localparam int H = 16;
    localparam int V = 4;
    localparam int N = H * V;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] solid;
    logic        tvalid;
    logic        tready;
    logic [23:0] tdata;
    logic        tuser;
    logic        done;
    logic [15:0] cnt;

    typedef struct packed {
        logic        last;
        logic        sof;
        logic [23:0] d;
    } beat_t;

    beat_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    beats = 0;
    int    exp_cnt = 0;
    logic  exp_done = 1'b0;
    logic  gap_chk = 1'b0;
    logic  stall_q = 1'b0;
    logic  rnd_ready = 1'b0;
    logic [23:0] prev_d;
    logic        prev_u;

    video_tpg #(.H_ACTIVE(H), .V_ACTIVE(V), .CHK_LOG2(2)) u_dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .mode_i        (mode),
        .solid_rgb_i   (solid),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tuser  (tuser),
        .frame_done_o  (done),
        .frame_cnt_o   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_pix(int m, logic [23:0] s, int x, int y);
        logic [23:0] p;
        case (m)
            0: begin
                case (x / (H / 8))
                    0: p = 24'hFFFFFF;
                    1: p = 24'h00FFFF;
                    2: p = 24'hFFFF00;
                    3: p = 24'h00FF00;
                    4: p = 24'hFF00FF;
                    5: p = 24'h0000FF;
                    6: p = 24'hFF0000;
                    default: p = 24'h000000;
                endcase
            end
            1: p = (((x >> 2) ^ (y >> 2)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            2: p = {8'((x + y) & 255), 8'(y & 255), 8'(x & 255)};
            default: p = s;
        endcase
        return p;
    endfunction

    task automatic push_frame(input int m, input logic [23:0] s);
        beat_t b;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                b.last = (x == H - 1) && (y == V - 1);
                b.sof  = (x == 0) && (y == 0);
                b.d    = exp_pix(m, s, x, y);
                q.push_back(b);
            end
        end
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (beats < n && c < 4000) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("wait_beats", 32'(beats >= n), 32'd1);
    endtask

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stall_q  = 1'b0;
            exp_done = 1'b0;
            gap_chk  = 1'b0;
        end else begin
            check("done", 32'(done), 32'(exp_done));
            check("frame_cnt", 32'(cnt), exp_cnt);
            exp_done = 1'b0;
            if (gap_chk) check("nogap_valid", 32'(tvalid), 32'd1);
            gap_chk = 1'b0;
            if ((beats % N) != 0) check("inframe_valid", 32'(tvalid), 32'd1);
            if (stall_q) begin
                check("stall_valid", 32'(tvalid), 32'd1);
                check("stall_data", 32'(tdata), 32'(prev_d));
                check("stall_user", 32'(tuser), 32'(prev_u));
            end
            if (tvalid && tready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("tdata", 32'(tdata), 32'(e.d));
                    check("tuser", 32'(tuser), 32'(e.sof));
                    beats++;
                    if (e.last) begin
                        exp_done = 1'b1;
                        exp_cnt  = (exp_cnt + 1) & 16'hFFFF;
                        gap_chk  = (q.size() > 0);
                    end
                end
            end
            stall_q = tvalid && !tready;
            prev_d  = tdata;
            prev_u  = tuser;
        end
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'd0;
        solid  = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(tvalid), 32'd0);
        check("rst_data", 32'(tdata), 32'd0);
        check("rst_user", 32'(tuser), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_valid", 32'(tvalid), 32'd0);

        // Frame A: bars at full throughput, then solid mode requested mid-frame
        mode   = 2'd0;
        enable = 1'b1;
        push_frame(0, 24'h0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(tvalid), 32'd1);
        check("lat_sof", 32'(tuser), 32'd1);
        check("lat_data", 32'(tdata), 32'hFFFFFF);
        wait_beats(20);
        mode  = 2'd3;
        solid = 24'h123456;
        push_frame(3, 24'h123456);

        // Frame B: solid with random back-pressure, ramp requested mid-frame
        rnd_ready = 1'b1;
        wait_beats(N + 10);
        mode  = 2'd2;
        solid = 24'hABCDEF;
        push_frame(2, 24'h0);
        wait_beats(2 * N + 5);
        mode = 2'd1;
        push_frame(1, 24'h0);

        // Frame D: checker; enable dropped mid-frame must not truncate it
        wait_beats(3 * N + 10);
        enable = 1'b0;
        mode   = 2'd0;
        wait_beats(4 * N);
        repeat (3) @(posedge clk);
        #1;
        check("end_idle_valid", 32'(tvalid), 32'd0);
        check("end_cnt", 32'(cnt), 32'd4);
        check("queue_empty", 32'(q.size()), 32'd0);

        // Reset in the middle of a frame
        rnd_ready = 1'b0;
        enable    = 1'b1;
        push_frame(0, 24'h0);
        wait_beats(4 * N + 30);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(tvalid), 32'd0);
        check("mrst_data", 32'(tdata), 32'd0);
        check("mrst_user", 32'(tuser), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_cnt", 32'(cnt), 32'd0);
        q.delete();
        beats   = 0;
        exp_cnt = 0;
        enable  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(tvalid), 32'd0);
        check("post_rst_cnt", 32'(cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
